fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Owns the word-addressed program counter and sequences instruction fetch for the multi-cycle core.
- Issues one instruction-memory request at a time, buffers the returned word for decode, and advances the PC only when decode accepts it.
- Applies branch/jump redirects from execute and discards stale memory responses left in flight by a redirect.

Parameters:
- WIDTH, 30, PC width in words (byte address = {pc, 2'b00}).
- RESET_VEC, 0, PC value loaded on reset (WIDTH bits).

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- redirect_valid  in  1  execute requests a PC change this cycle.
- redirect_addr  in  WIDTH  target word address.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  WIDTH  fetch word address.
- imem_req_ready  in  1  memory accepts the request.
- imem_rsp_valid  in  1  read data valid (exactly one per accepted request, 1+ cycles after acceptance).
- imem_rsp_data  in  32  instruction word.
- inst_valid  out  1  buffered instruction valid to decode.
- inst_data  out  32  buffered instruction.
- inst_pc  out  WIDTH  PC of inst_data.
- inst_npc  out  WIDTH  inst_pc + 1, mod 2^WIDTH.
- inst_ready  in  1  decode accepts the instruction.

Behaviour:
- Registers: pc, state, inst buffer (data/pc). All outputs are decoded from registers only; there are no combinational input-to-output paths.
- Reset (async, while rst_n=0): state=BOOT, pc=RESET_VEC, imem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=RESET_VEC.
- States:
  - BOOT: imem_req_valid=0. Next cycle -> REQ. Gives one idle cycle after reset release.
  - REQ: imem_req_valid=1, imem_req_addr=pc. On imem_req_ready -> WAIT.
  - WAIT: request outstanding. On imem_rsp_valid, capture data and pc into the buffer, then -> HOLD.
  - HOLD: inst_valid=1, and the buffer is stable. On inst_ready, pc<=pc+1 (wraps from all-ones to 0), then -> REQ.
  - DRAIN: stale response outstanding, imem_req_valid=0. On imem_rsp_valid, discard the data, then -> REQ.
- Redirect: redirect_valid has priority over every other event, and pc<=redirect_addr in all states.
  - BOOT: -> REQ.
  - REQ without imem_req_ready: stays REQ; the next request uses the new pc.
  - REQ with imem_req_ready in the same cycle: the accepted request is stale -> DRAIN.
  - WAIT without imem_rsp_valid: -> DRAIN.
  - WAIT with imem_rsp_valid in the same cycle: the response is discarded -> REQ.
  - HOLD: inst_valid drops the next cycle. A same-cycle inst_ready is overridden: pc is not incremented and the instruction is squashed -> REQ.
  - DRAIN: target is updated, stays DRAIN (last redirect wins); a same-cycle rsp -> REQ.
- Throughput: at most 1 instruction per 3 cycles with a 1-cycle memory (REQ, WAIT, HOLD). Further pipelining is out of scope.
- Reset mid-transaction: everything returns to the reset values immediately. Any in-flight response after reset release is not tracked; the memory must also be reset by rst_n.

Optional Feature:
- Macro: FETCH_SEQ_PERF_EN.
- Defined: adds outputs perf_fetched [31:0] and perf_squashed [31:0], both reset to 0 and wrapping.
  - perf_fetched increments on each inst_valid&&inst_ready handshake that is not overridden by a redirect.
  - perf_squashed increments on each discarded response (DRAIN receipt, or a WAIT response coinciding with a redirect) and on each squashed HOLD instruction.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, RESET_VEC=0x100, memory ready=1, 1-cycle latency, inst_ready=1 -> imem_req_addr sequence 0x100, 0x101, 0x102; inst_pc matches, inst_npc=inst_pc+1; first request is 2 cycles after reset release.
- inst_ready held 0 for 5 cycles in HOLD -> inst_valid, inst_data, inst_pc stable; no new imem_req_valid; pc advances exactly once on release.
- redirect_valid with addr 0x200 in the same cycle as imem_req_ready for 0x101 -> DRAIN; the 0x101 response is discarded; next request is 0x200; perf_squashed=1 if FETCH_SEQ_PERF_EN is defined.
- redirect_valid in HOLD coinciding with inst_ready -> pc=redirect_addr, not +1; inst_valid=0 the next cycle.
- pc=0x3FFFFFFF (WIDTH=30) accepted -> inst_npc=0, next request address 0.
- rst_n asserted during WAIT -> outputs return to reset values asynchronously; after release the sequence restarts at RESET_VEC.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the word PC, issues one imem request at a time and buffers the result for decode.
// Optional performance counters are enabled with `define FETCH_SEQ_PERF_EN.
module fetch_sequencer #(
  parameter int               WIDTH     = 30,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_addr,
  output logic             imem_req_valid,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_req_ready,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  output logic             inst_valid,
  output logic [31:0]      inst_data,
  output logic [WIDTH-1:0] inst_pc,
  output logic [WIDTH-1:0] inst_npc,
`ifdef FETCH_SEQ_PERF_EN
  output logic [31:0]      perf_fetched,
  output logic [31:0]      perf_squashed,
`endif
  input  logic             inst_ready
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  logic [WIDTH-1:0] pc;
  logic [31:0]      buf_data;
  logic [WIDTH-1:0] buf_pc;

  // A redirect always retargets pc; the state decides whether an in-flight response becomes stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_BOOT;
      pc       <= RESET_VEC;
      buf_data <= '0;
      buf_pc   <= RESET_VEC;
    end else begin
      if (redirect_valid)
        pc <= redirect_addr;
      case (state)
        S_BOOT:
          state <= S_REQ;
        S_REQ:
          if (imem_req_ready)
            state <= redirect_valid ? S_DRAIN : S_WAIT;
        S_WAIT:
          if (imem_rsp_valid) begin
            if (redirect_valid) begin
              state <= S_REQ;
            end else begin
              buf_data <= imem_rsp_data;
              buf_pc   <= pc;
              state    <= S_HOLD;
            end
          end else if (redirect_valid) begin
            state <= S_DRAIN;
          end
        S_HOLD:
          if (redirect_valid) begin
            state <= S_REQ;
          end else if (inst_ready) begin
            pc    <= pc + ONE;
            state <= S_REQ;
          end
        S_DRAIN:
          if (imem_rsp_valid)
            state <= S_REQ;
        default:
          state <= S_BOOT;
      endcase
    end
  end

  assign imem_req_valid = (state == S_REQ);
  assign imem_req_addr  = pc;
  assign inst_valid     = (state == S_HOLD);
  assign inst_data      = buf_data;
  assign inst_pc        = buf_pc;
  assign inst_npc       = buf_pc + ONE;

`ifdef FETCH_SEQ_PERF_EN
  logic fetched_evt;
  logic squashed_evt;

  // Squashes cover stale responses (in DRAIN, or in WAIT alongside a redirect) and redirected HOLD instructions.
  always_comb begin
    fetched_evt  = (state == S_HOLD) && inst_ready && !redirect_valid;
    squashed_evt = ((state == S_DRAIN) && imem_rsp_valid) ||
                   ((state == S_WAIT) && imem_rsp_valid && redirect_valid) ||
                   ((state == S_HOLD) && redirect_valid);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched  <= '0;
      perf_squashed <= '0;
    end else begin
      if (fetched_evt)
        perf_fetched <= perf_fetched + 32'd1;
      if (squashed_evt)
        perf_squashed <= perf_squashed + 32'd1;
    end
  end
`endif

endmodule
